// File: rtl/rule110_pkg.sv
// Shared definitions for the rule-110 sequencer: default geometry, FSM
// state encoding and the single-cell rule-110 update function.
`timescale 1ns/1ps
package rule110_pkg;

  localparam int unsigned DEF_CELLS = 64;
  localparam int unsigned DEF_WORD  = 8;
  localparam int unsigned GENS_W    = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STEP   = 3'd2,
    ST_STREAM = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

  // Rule 110 for one cell: l = left (higher index), c = centre, r = right.
  function automatic logic rule110_cell(input logic l, input logic c, input logic r);
    return (l & c & ~r) | (~l & c) | (~c & r);
  endfunction

endpackage

// File: rtl/rule110_step.sv
// Combinational next generation of a CELLS-wide rule-110 automaton.
// Ports:
//   cells_i   current generation (bit i = cell i)
//   next_c_o  next generation; cells outside 0..CELLS-1 read as 0
`timescale 1ns/1ps
module rule110_step
  import rule110_pkg::*;
#(
  parameter int unsigned CELLS = DEF_CELLS
) (
  input  logic [CELLS-1:0] cells_i,
  output logic [CELLS-1:0] next_c_o
);

  // Zero guard cell on each side so the edges see no wrap-around.
  logic [CELLS+1:0] padded;
  assign padded = {1'b0, cells_i, 1'b0};

  for (genvar i = 0; i < CELLS; i++) begin : g_cell
    assign next_c_o[i] = rule110_cell(padded[i+2], padded[i+1], padded[i]);
  end

endmodule

// File: rtl/rule110_seq_ctrl.sv
// Rule-110 run controller: loads a seed word-serially, runs a number of
// generations and streams each generation out MSW first.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   ld_valid/ld_data/ld_ready   seed word input (IDLE only)
//   start, gens         begin a run of gens generations (IDLE only)
//   out_valid/out_data/out_ready stream of generation words
//   busy                high whenever not IDLE
//   done                one-cycle pulse at the end of a run
`timescale 1ns/1ps
module rule110_seq_ctrl
  import rule110_pkg::*;
#(
  parameter int unsigned CELLS = DEF_CELLS,
  parameter int unsigned WORD  = DEF_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  input  logic [WORD-1:0]   ld_data,
  output logic              ld_ready,
  input  logic              start,
  input  logic [GENS_W-1:0] gens,
  output logic              out_valid,
  output logic [WORD-1:0]   out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int unsigned NWORDS = CELLS / WORD;
  localparam int unsigned IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  state_e              state_q, state_d;
  logic [CELLS-1:0]    cells_q, cells_d;
  logic [GENS_W-1:0]   rem_q, rem_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [WORD-1:0]     out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ld_ready_q, ld_ready_d;
  logic [CELLS-1:0]    step_next;

  rule110_step #(.CELLS(CELLS)) u_step (
    .cells_i  (cells_q),
    .next_c_o (step_next)
  );

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d    = state_q;
    cells_d    = cells_q;
    rem_d      = rem_q;
    idx_d      = idx_q;
    out_data_d = out_data_q;
    done_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Load is applied before start so a same-cycle word joins the seed.
        if (ld_valid && ld_ready) begin
          cells_d = CELLS'({cells_q, ld_data});
        end
        if (start) begin
          if (gens != '0) begin
            rem_d   = gens;
            state_d = ST_STEP;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_STEP: begin
        cells_d = step_next;
        rem_d   = rem_q - GENS_W'(1);
        idx_d   = '0;
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (out_ready) begin
          if (idx_q == IDX_W'(NWORDS - 1)) begin
            idx_d   = '0;
            state_d = (rem_q != '0) ? ST_STEP : ST_FINISH;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      // LOAD is never entered (seed loading happens in IDLE); recover to IDLE.
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Word select follows the next cells/index so out_data is registered.
    for (int unsigned k = 0; k < NWORDS; k++) begin
      if (idx_d == IDX_W'(k)) begin
        out_data_d = cells_d[CELLS-1-k*WORD -: WORD];
      end
    end

    out_valid_d = (state_d == ST_STREAM);
    busy_d      = (state_d != ST_IDLE);
    ld_ready_d  = (state_d == ST_IDLE);
    done_d      = done_d | (state_d == ST_FINISH);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cells_q     <= '0;
      rem_q       <= '0;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ld_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cells_q     <= cells_d;
      rem_q       <= rem_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ld_ready_q  <= ld_ready_d;
    end
  end

  assign ld_ready  = ld_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
